// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package ifq_pkg;
  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} ifqState_e;
  localparam logic [15:0] NOP         = 16'h0000;
  localparam logic [15:0] DISCARD_MAX = 16'hFFFF;
endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of {instruction, pc} with flush and a registered head entry.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [15:0]            pushData,
  input  logic [AW-1:0]          pushPc,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   headValid,
  output logic [15:0]            headData,
  output logic [AW-1:0]          headPc,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][15:0]   dataMem;
  logic [DEPTH-1:0][AW-1:0] pcMem;
  logic [PW-1:0]            wrPtr, rdPtr, rdNext;
  logic [CW-1:0]            remain;
  logic                     doPop;

  assign doPop  = pop & (count != '0);
  assign rdNext = rdPtr + PW'(doPop);
  assign remain = count - CW'(doPop);
  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));

  // Push is never issued together with flush, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      dataMem[wrPtr] <= pushData;
      pcMem[wrPtr]   <= pushPc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      headValid <= 1'b0;
      headData  <= NOP;
      headPc    <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      rdPtr <= rdNext;
      count <= remain + CW'(push);
      // Head is precomputed so outputs never see deq/redirect combinationally.
      if (remain == '0) begin
        headValid <= push;
        headData  <= push ? pushData : NOP;
        headPc    <= push ? pushPc : '0;
      end else begin
        headValid <= 1'b1;
        headData  <= dataMem[rdNext];
        headPc    <= pcMem[rdNext];
      end
    end
  end
endmodule

// File: rtl/ifetch_queue.sv
// Prefetch queue: issues word reads to imem, buffers responses, drops stale ones after a redirect.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_data,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          deq,
  output logic          instr_valid,
  output logic [15:0]   instr,
  output logic [AW-1:0] instr_pc,
  output logic          empty,
  output logic          full,
  output logic [15:0]   discard_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;

  ifqState_e     state, stateNext;
  logic [AW-1:0] fetchPc, drainAddr;
  logic [CW-1:0] count;
  logic          pend, runEn, fire, keepPend, push, pop;

  assign fire     = imem_req & imem_ack;
  assign keepPend = imem_req & ~imem_ack;
  assign push     = fire & (state == RUN) & ~redirect;
  assign pop      = deq & ~redirect;

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      RUN:     if (redirect && keepPend) stateNext = DRAIN;
      DRAIN:   if (fire) stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  // An outstanding request is held until acked; a new one needs a free slot.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fetchPc;
    if (runEn) begin
      case (state)
        RUN:     imem_req = pend | (count < CW'(DEPTH));
        DRAIN: begin
          imem_req  = 1'b1;
          imem_addr = drainAddr;
        end
        default: imem_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      runEn       <= 1'b0;
      pend        <= 1'b0;
      fetchPc     <= '0;
      drainAddr   <= '0;
      discard_cnt <= '0;
    end else begin
      runEn <= 1'b1;
      pend  <= keepPend;
      if (redirect) begin
        fetchPc <= redirect_pc;
        if (state == RUN && keepPend) drainAddr <= fetchPc;
      end else if (push) begin
        fetchPc <= fetchPc + AW'(1);
      end
      if (fire && (redirect || state == DRAIN) && discard_cnt != DISCARD_MAX)
        discard_cnt <= discard_cnt + 16'd1;
    end
  end

  ifq_fifo #(.DEPTH(DEPTH), .AW(AW)) uFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pushData (imem_data),
    .pushPc   (fetchPc),
    .pop      (pop),
    .flush    (redirect),
    .headValid(instr_valid),
    .headData (instr),
    .headPc   (instr_pc),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue; memory returns data = addr ^ 16'hA500.
module tb_ifetch_queue;
  logic        clk = 1'b0, reset = 1'b1;
  logic        imem_req, imem_ack = 1'b0, redirect = 1'b0, deq = 1'b0;
  logic        instr_valid, empty, full;
  logic [15:0] imem_addr, imem_data = '0, redirect_pc = '0;
  logic [15:0] instr, instr_pc, discard_cnt;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(4), .AW(16)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .deq(deq),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .empty(empty), .full(full), .discard_cnt(discard_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    imem_data = imem_addr ^ 16'hA500;
  endtask

  task automatic chkReset(input string tag);
    chk({tag, "_req"},   imem_req, 0);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_pc"},    instr_pc, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"},  full, 0);
    chk({tag, "_disc"},  discard_cnt, 0);
  endtask

  task automatic restart(input logic ackV, input logic deqV);
    reset = 1'b1; redirect = 1'b0; imem_ack = 1'b0; deq = 1'b0;
    tick(); tick();
    reset = 1'b0; imem_ack = ackV; deq = deqV;
    tick();
  endtask

  initial begin
    tick(); tick();
    chkReset("rst");

    // back-to-back streaming
    reset = 1'b0; imem_ack = 1'b1; deq = 1'b1;
    tick();
    chk("s_req0", imem_req, 1);
    chk("s_addr0", imem_addr, 0);
    tick();
    chk("s_valid", instr_valid, 1);
    chk("s_pc0", instr_pc, 0);
    chk("s_instr0", instr, 16'hA500);
    chk("s_addr1", imem_addr, 1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("s_pc", instr_pc, k);
      chk("s_instr", instr, 16'(k) ^ 16'hA500);
    end

    // fill to full with a pending request at count 3
    restart(1'b1, 1'b0);
    chk("f_req0", imem_req, 1);
    tick(); tick(); tick();
    chk("f_addr3", imem_addr, 3);
    chk("f_notfull", full, 0);
    imem_ack = 1'b0;
    tick();
    chk("f_pend_req", imem_req, 1);
    tick();
    chk("f_pend_req2", imem_req, 1);
    chk("f_pend_addr", imem_addr, 3);
    imem_ack = 1'b1;
    tick();
    chk("f_full", full, 1);
    chk("f_req_off", imem_req, 0);
    chk("f_head", instr_pc, 0);
    tick();
    chk("f_req_stay", imem_req, 0);
    deq = 1'b1;
    tick();
    chk("f_full_clr", full, 0);
    chk("f_pc1", instr_pc, 1);
    chk("f_req_on", imem_req, 1);
    chk("f_addr4", imem_addr, 4);
    tick();
    chk("f_pc2", instr_pc, 2);
    tick();
    chk("f_pc3", instr_pc, 3);

    // redirect while a slow request is pending
    restart(1'b0, 1'b1);
    tick();
    chk("d_req", imem_req, 1);
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    chk("d_hold_req", imem_req, 1);
    chk("d_hold_addr", imem_addr, 0);
    chk("d_valid0", instr_valid, 0);
    chk("d_empty", empty, 1);
    imem_ack = 1'b1;
    tick();
    chk("d_disc1", discard_cnt, 1);
    chk("d_nopush", instr_valid, 0);
    chk("d_newaddr", imem_addr, 16'h0040);
    tick();
    chk("d_valid", instr_valid, 1);
    chk("d_pc", instr_pc, 16'h0040);
    chk("d_instr", instr, 16'hA540);

    // redirect coinciding with req&ack and deq
    redirect = 1'b1; redirect_pc = 16'h1230;
    tick();
    redirect = 1'b0;
    chk("r_disc2", discard_cnt, 2);
    chk("r_valid0", instr_valid, 0);
    chk("r_empty", empty, 1);
    chk("r_full", full, 0);
    chk("r_req", imem_req, 1);
    chk("r_addr", imem_addr, 16'h1230);
    tick();
    chk("r_pc", instr_pc, 16'h1230);

    // address wrap
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    chk("w_disc3", discard_cnt, 3);
    chk("w_addr", imem_addr, 16'hFFFE);
    tick(); tick();
    chk("w_pc", instr_pc, 16'hFFFF);
    chk("w_instr", instr, 16'h5AFF);
    chk("w_addr0", imem_addr, 0);
    tick();
    chk("w_pc0", instr_pc, 0);
    chk("w_instr0", instr, 16'hA500);

    // reset with two entries queued and a request pending
    deq = 1'b0;
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    tick(); tick();
    chk("p_disc4", discard_cnt, 4);
    imem_ack = 1'b0;
    tick();
    chk("p_req", imem_req, 1);
    chk("p_addr", imem_addr, 16'h0102);
    chk("p_pc", instr_pc, 16'h0100);
    chk("p_empty", empty, 0);
    reset = 1'b1;
    tick();
    chkReset("rst_pend");

    // reset in DRAIN
    reset = 1'b0;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 16'h0300;
    tick();
    redirect = 1'b0;
    chk("x_drain_req", imem_req, 1);
    chk("x_drain_addr", imem_addr, 0);
    reset = 1'b1;
    tick();
    chkReset("rst_drain");
    reset = 1'b0;
    tick();
    chk("x_restart_req", imem_req, 1);
    chk("x_restart_addr", imem_addr, 0);
    imem_ack = 1'b1;
    tick();
    chk("x_run_valid", instr_valid, 1);
    chk("x_run_pc", instr_pc, 0);
    chk("x_run_addr", imem_addr, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
